// File: rtl/demux_pkg.sv
// Shared types and sizing for the registered 1:2 demux and its per-channel buffers.
package demux_pkg;

  typedef enum logic {
    CH1 = 1'b0,
    CH2 = 1'b1
  } demux_ch_e;

  localparam int DEMUX_DEPTH = 2;
  localparam int DEMUX_CNT_W = 2;

  function automatic demux_ch_e demux_flip(input demux_ch_e ch);
    return (ch == CH1) ? CH2 : CH1;
  endfunction

endpackage

// File: rtl/demux_ch_buf.sv
// 2-entry output buffer for one demux channel: a pushed word is visible the cycle after the push.
// Ready-in is the consumer's; full is exported so the input side stops pushing.
import demux_pkg::*;

module demux_ch_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready
);

  localparam logic [DEMUX_CNT_W-1:0] FULL_CNT = DEMUX_CNT_W'(DEMUX_DEPTH);

  logic [WIDTH-1:0]       mem [DEMUX_DEPTH];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [DEMUX_CNT_W-1:0] count;
  logic                   pop;

  assign y_valid = (count != '0);
  assign full    = (count == FULL_CNT);
  assign pop     = y_valid && y_ready;
  assign y       = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEMUX_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  // Pointers are 1 bit, so 1 -> 0 wrap is plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux_1_2_seq.sv
// Registered 1:2 demux, one-cycle latency into per-channel 2-entry buffers; d_ready is !full of the target channel only.
// Build with DEMUX_AUTO_ALT_EN to ignore s and alternate channels on every accepted beat.
import demux_pkg::*;

module demux_1_2_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic             s,
  output logic [WIDTH-1:0] y1,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic [WIDTH-1:0] y2,
  output logic             y2_valid,
  input  logic             y2_ready
);

  demux_ch_e target;
  logic      accept;
  logic      full1;
  logic      full2;
  logic      push1;
  logic      push2;

`ifdef DEMUX_AUTO_ALT_EN
  demux_ch_e state;
  demux_ch_e state_nxt;
  logic      unused_s;

  assign unused_s = s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CH1;
    else        state <= state_nxt;
  end

  // Only an accepted beat advances the toggle; a full target stalls rather than skipping.
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = demux_flip(state);
  end

  assign target = state;
`else
  assign target = demux_ch_e'(s);
`endif

  assign d_ready = (target == CH1) ? !full1 : !full2;
  assign accept  = d_valid && d_ready;
  assign push1   = accept && (target == CH1);
  assign push2   = accept && (target == CH2);

  demux_ch_buf #(.WIDTH(WIDTH)) u_buf1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push1),
    .data    (d),
    .full    (full1),
    .y       (y1),
    .y_valid (y1_valid),
    .y_ready (y1_ready)
  );

  demux_ch_buf #(.WIDTH(WIDTH)) u_buf2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push2),
    .data    (d),
    .full    (full2),
    .y       (y2),
    .y_valid (y2_valid),
    .y_ready (y2_ready)
  );

endmodule

// File: tb/tb_demux_1_2_seq.sv
// Directed bench for demux_1_2_seq: vector table plus hand sequences for streaming, mid-run reset and alternating mode.
module tb_demux_1_2_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] d;
  logic       d_valid;
  logic       d_ready;
  logic       s;
  logic [7:0] y1;
  logic       y1_valid;
  logic       y1_ready;
  logic [7:0] y2;
  logic       y2_valid;
  logic       y2_ready;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       s;
    logic       r1;
    logic       r2;
    logic       e_rdy;
    logic       e_y1v;
    logic [7:0] e_y1;
    logic       e_y2v;
    logic [7:0] e_y2;
  } vec_t;

  demux_1_2_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .s        (s),
    .y1       (y1),
    .y1_valid (y1_valid),
    .y1_ready (y1_ready),
    .y2       (y2),
    .y2_valid (y2_valid),
    .y2_ready (y2_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then settle before checking.
  task automatic step(input logic [7:0] dv, input logic v, input logic sv, input logic r1, input logic r2);
    @(negedge clk);
    d        = dv;
    d_valid  = v;
    s        = sv;
    y1_ready = r1;
    y2_ready = r2;
    #1;
  endtask

  vec_t vt[11];

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    d        = '0;
    d_valid  = 1'b0;
    s        = 1'b0;
    y1_ready = 1'b0;
    y2_ready = 1'b0;

    // y columns only matter when the matching valid is expected high.
    //          d      v  s  r1 r2  rdy y1v y1     y2v y2
    vt[0]  = '{8'hA5, 1, 0, 1, 1,  1,  0,  8'h00, 0,  8'h00};
    vt[1]  = '{8'h3C, 1, 1, 1, 1,  1,  1,  8'hA5, 0,  8'h00};
    vt[2]  = '{8'h00, 0, 0, 1, 1,  1,  0,  8'h00, 1,  8'h3C};
    vt[3]  = '{8'h00, 0, 0, 1, 1,  1,  0,  8'h00, 0,  8'h00};
    vt[4]  = '{8'h01, 1, 0, 0, 1,  1,  0,  8'h00, 0,  8'h00};
    vt[5]  = '{8'h02, 1, 0, 0, 1,  1,  1,  8'h01, 0,  8'h00};
    vt[6]  = '{8'h03, 1, 0, 0, 1,  0,  1,  8'h01, 0,  8'h00};
    vt[7]  = '{8'h03, 1, 1, 0, 1,  1,  1,  8'h01, 0,  8'h00};
    vt[8]  = '{8'h00, 0, 0, 1, 0,  0,  1,  8'h01, 1,  8'h03};
    vt[9]  = '{8'h00, 0, 0, 1, 1,  1,  1,  8'h02, 1,  8'h03};
    vt[10] = '{8'h00, 0, 0, 1, 1,  1,  0,  8'h00, 0,  8'h00};

    #12;
    chk("rst_d_ready", 0, {7'd0, d_ready}, 8'd1);
    chk("rst_y1_valid", 0, {7'd0, y1_valid}, 8'd0);
    chk("rst_y2_valid", 0, {7'd0, y2_valid}, 8'd0);
    chk("rst_y1", 0, y1, 8'h00);
    chk("rst_y2", 0, y2, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef DEMUX_AUTO_ALT_EN
    for (int i = 0; i < 11; i++) begin
      step(vt[i].d, vt[i].v, vt[i].s, vt[i].r1, vt[i].r2);
      chk("vec_d_ready", i, {7'd0, d_ready}, {7'd0, vt[i].e_rdy});
      chk("vec_y1_valid", i, {7'd0, y1_valid}, {7'd0, vt[i].e_y1v});
      chk("vec_y2_valid", i, {7'd0, y2_valid}, {7'd0, vt[i].e_y2v});
      if (vt[i].e_y1v) chk("vec_y1", i, y1, vt[i].e_y1);
      if (vt[i].e_y2v) chk("vec_y2", i, y2, vt[i].e_y2);
    end

    // Channel 1 held at one entry: push and pop every cycle.
    step(8'h40, 1, 0, 1, 1);
    chk("strm_first_valid", 0, {7'd0, y1_valid}, 8'd0);
    for (int i = 1; i <= 10; i++) begin
      step(8'h40 + 8'(i), 1, 0, 1, 1);
      chk("strm_d_ready", i, {7'd0, d_ready}, 8'd1);
      chk("strm_y1_valid", i, {7'd0, y1_valid}, 8'd1);
      chk("strm_y1", i, y1, 8'h40 + 8'(i - 1));
    end
    step(8'h00, 0, 0, 1, 1);
    chk("strm_last", 0, y1, 8'h4A);
    chk("strm_last_valid", 0, {7'd0, y1_valid}, 8'd1);
    step(8'h00, 0, 0, 1, 1);
    chk("strm_empty", 0, {7'd0, y1_valid}, 8'd0);

    // Fill both channels, then reset between edges.
    step(8'hAA, 1, 0, 0, 0);
    step(8'hBB, 1, 0, 0, 0);
    step(8'hCC, 1, 1, 0, 0);
    step(8'hDD, 1, 1, 0, 0);
    step(8'hEE, 1, 1, 0, 0);
    chk("full2_d_ready", 0, {7'd0, d_ready}, 8'd0);
    chk("full2_y2", 0, y2, 8'hCC);
    step(8'hEE, 1, 0, 0, 0);
    chk("full1_d_ready", 0, {7'd0, d_ready}, 8'd0);
    chk("full1_y1", 0, y1, 8'hAA);
    d_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_y1_valid", 0, {7'd0, y1_valid}, 8'd0);
    chk("mrst_y2_valid", 0, {7'd0, y2_valid}, 8'd0);
    chk("mrst_y1", 0, y1, 8'h00);
    chk("mrst_y2", 0, y2, 8'h00);
    chk("mrst_d_ready", 0, {7'd0, d_ready}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 0, i[0], 1, 1);
      chk("post_rst_y1_valid", i, {7'd0, y1_valid}, 8'd0);
      chk("post_rst_y2_valid", i, {7'd0, y2_valid}, 8'd0);
    end
    step(8'h77, 1, 1, 1, 1);
    step(8'h00, 0, 0, 1, 1);
    chk("post_rst_y2", 0, y2, 8'h77);
    chk("post_rst_y2v", 0, {7'd0, y2_valid}, 8'd1);
    chk("post_rst_y1v", 0, {7'd0, y1_valid}, 8'd0);
`else
    // Alternating mode: s is noise, targets go CH1, CH2, CH1, CH2.
    for (int i = 0; i < 4; i++) begin
      step(8'h10 + 8'(i), 1, 1'($urandom_range(0, 1)), 0, 0);
      chk("alt_push_ready", i, {7'd0, d_ready}, 8'd1);
    end
    step(8'h14, 1, 1'($urandom_range(0, 1)), 1, 0);
    chk("alt_full_ready", 0, {7'd0, d_ready}, 8'd0);
    chk("alt_y1_head", 0, y1, 8'h10);
    chk("alt_y2_head", 0, y2, 8'h11);
    step(8'h14, 1, 1'($urandom_range(0, 1)), 1, 0);
    chk("alt_y1_second", 0, y1, 8'h12);
    chk("alt_ready_ch1", 0, {7'd0, d_ready}, 8'd1);
    step(8'h15, 1, 1'($urandom_range(0, 1)), 1, 0);
    chk("alt_stall_ch2", 0, {7'd0, d_ready}, 8'd0);
    chk("alt_y1_14", 0, y1, 8'h14);
    step(8'h15, 1, 1'($urandom_range(0, 1)), 1, 0);
    chk("alt_ch1_empty", 0, {7'd0, y1_valid}, 8'd0);
    chk("alt_still_stalled", 0, {7'd0, d_ready}, 8'd0);
    step(8'h15, 1, 1'($urandom_range(0, 1)), 1, 1);
    chk("alt_y2_11", 0, y2, 8'h11);
    step(8'h15, 1, 1'($urandom_range(0, 1)), 1, 1);
    chk("alt_y2_13", 0, y2, 8'h13);
    chk("alt_unstalled", 0, {7'd0, d_ready}, 8'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_1_2_seq.md
# demux_1_2_seq

Registered 1-to-2 demultiplexer: the receiving-side counterpart of the team's 2:1 mux. It takes a single valid/ready input stream and steers each accepted word to one of two output channels. Each output channel has its own 2-entry buffer with an independent valid/ready handshake, so one stalled consumer never blocks words bound for the other channel. It sits after a shared link that was merged by the 2:1 mux and restores the two original streams.

## Interface

Parameters:

- `WIDTH`, 8: data width of the input word and of both output words.

Ports:

- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `d`, input, WIDTH: input data word.
- `d_valid`, input, 1: `d` (and `s`) are presented this cycle.
- `d_ready`, output, 1: block accepts the word this cycle.
- `s`, input, 1: channel select; 0 routes to `y1`, 1 routes to `y2`. Sampled only on an accepted beat.
- `y1`, output, WIDTH: head word of channel 1.
- `y1_valid`, output, 1: `y1` holds a valid word.
- `y1_ready`, input, 1: channel 1 consumer accepts `y1`.
- `y2`, output, WIDTH: head word of channel 2.
- `y2_valid`, output, 1: `y2` holds a valid word.
- `y2_ready`, input, 1: channel 2 consumer accepts `y2`.

## Operation

- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- Input accept: a beat is accepted when `d_valid && d_ready`.
- `d_ready` is `!full` of the target channel's buffer; the target is `s`, or the toggle state when `DEMUX_AUTO_ALT_EN` is defined.
- `d_ready` is combinational from the select and the registered full flag. It has no dependence on `y*_ready`, so there is no pass-through path.
- Per-channel buffer: 2-entry FIFO built from `wr_ptr`, `rd_ptr` (1 bit each) and `count` (0..2).
  - Push: an accepted beat targeting this channel.
  - Pop: `yN_valid && yN_ready`.
- Boundary behaviour:
  - Push and pop in the same cycle with `count == 1`: count stays 1, pointers both advance.
  - Push with `count == 2`: cannot occur, because `d_ready` is low.
  - Pop with `count == 0`: cannot occur, because `yN_valid` is low.
  - Pointer wrap: 1 → 0, natural 1-bit overflow.
- Outputs: `yN = mem[rd_ptr]` and `yN_valid = (count != 0)`.
- `yN` holds its value while `yN_valid && !yN_ready`.
- Ordering is preserved within each channel. There is no ordering relation between channels.
- Reset, including mid-operation: all counts and pointers go to 0 and `yN_valid` goes to 0 immediately (asynchronous). `y1`/`y2` read 0; buffer storage is cleared. Buffered words are discarded. Toggle state returns to CH1.

## Timing

- Latency: a word accepted at edge N appears on `yN` with `yN_valid` high after edge N (visible in cycle N+1), provided the buffer was empty.
- Throughput: 1 word/cycle, sustained per channel while its consumer holds ready high.
- A freed entry (pop at edge N) allows `d_ready` for that channel in cycle N+1.
- When a channel is full and its consumer is stalled, `d_ready` stays low only while the select targets that channel. Switching `s` to the other channel unblocks the input the same cycle.

## Configuration

- Macro: `DEMUX_AUTO_ALT_EN`.
- Defined:
  - `s` is ignored.
  - A 1-bit toggle FSM (states CH1, CH2; reset to CH1) selects the target.
  - Each accepted beat moves CH1 → CH2 or CH2 → CH1; there is no transition without acceptance.
  - When the target is full, the input stalls on that channel and never skips to the other one.
- Undefined: the target is `s` and the toggle FSM is not built.

## Structure

- Package `demux_pkg` holds:
  - Channel enum `CH1 = 1'b0`, `CH2 = 1'b1`.
  - `DEMUX_DEPTH = 2`.
  - `DEMUX_CNT_W = 2`.
- Sub-module `demux_ch_buf`: the 2-entry FIFO, parameterised by `WIDTH` and instantiated twice. The top level contains only select/toggle logic and `d_ready` steering.

## Test plan

- Reset then idle: hold `rst_n = 0` → `d_ready = 1`, `y1_valid = y2_valid = 0`, `y1 = y2 = 0`.
- Routing:
  - Stimulus: `d = 8'hA5, s = 0`, then `d = 8'h3C, s = 1`, with both consumers ready.
  - Response: `y1 = A5` valid one cycle after accept; `y2 = 3C` valid the following cycle; each pulses valid once.
- Channel-1 full:
  - Stimulus: `y1_ready = 0`; push `8'h01, 8'h02` with `s = 0`, then present `8'h03` with `s = 0`.
  - Response: `d_ready = 0` on the third beat.
  - Follow-up: switch `s = 1` → `d_ready = 1` and `8'h03` lands in `y2`.
  - Follow-up: release `y1_ready` → `y1` drains 01 then 02.
- Simultaneous push/pop: hold channel 1 at `count = 1` with continuous push and `y1_ready = 1` for 10 cycles → `y1_valid` stays high and words appear in order, 1 per cycle.
- Reset mid-operation: both buffers full, assert `rst_n = 0` asynchronously between edges → valids drop immediately; after release no stale words appear.
- `DEMUX_AUTO_ALT_EN` build:
  - Stimulus: push 10, 11, 12, 13 with `s` random.
  - Response: `y1` gets 10, 12; `y2` gets 11, 13.
  - With `y2` stalled and full, the input stalls even when channel 1 is empty.
